// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and parameter-check helper for stream_fifo
package fifo_pkg;

    localparam int DEFAULT_DEPTH         = 256;
    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_AFULL_MARGIN  = 2;
    localparam int DEFAULT_AEMPTY_THRESH = 1;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// rtl/stream_fifo_if.sv - write/read handshakes, flush and occupancy status of stream_fifo
interface stream_fifo_if
    import fifo_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [LEVEL_W-1:0]    level;
    logic                  almost_full;
    logic                  almost_empty;

    // master: producer/consumer side driving the FIFO
    modport master (
        output flush, s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, level, almost_full, almost_empty
    );

    // slave: the FIFO itself
    modport slave (
        input  flush, s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, level, almost_full, almost_empty
    );

endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port block RAM, one write port and one registered read port
module fifo_ram #(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the FIFO head word, so it must come out of reset at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - valid/ready FWFT FIFO; level and thresholds enabled by STREAM_FIFO_LEVEL_EN
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int AFULL_THRESH  = DEPTH - DEFAULT_AFULL_MARGIN,
    parameter int AEMPTY_THRESH = DEFAULT_AEMPTY_THRESH
) (
    input  logic         clk,
    input  logic         rst,
    stream_fifo_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
        $error("stream_fifo: AFULL_THRESH must lie in 1..DEPTH");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_bad_aempty
        $error("stream_fifo: AEMPTY_THRESH must lie in 0..DEPTH-1");
    end

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [PTR_W-1:0]      ram_count;
    logic                  ram_empty;
    logic                  full;
    logic                  s_ready;
    logic                  m_valid;
    logic                  push;
    logic                  pop;
    logic                  load;
    logic [DATA_WIDTH-1:0] ram_rd_data;

`ifdef STREAM_FIFO_LEVEL_EN
    localparam int LVL_W = PTR_W;
    localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_LVL    = LVL_W'(AFULL_THRESH);
    localparam logic [LVL_W-1:0] AE_LVL    = LVL_W'(AEMPTY_THRESH);

    logic [LVL_W-1:0] level_q, level_d;
`else
    localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);
`endif

    // RAM words sit between rd_ptr and wr_ptr; the head word lives in the RAM read register.
    always_comb begin
        ram_count = wr_ptr_q - rd_ptr_q;
        ram_empty = (ram_count == '0);
`ifdef STREAM_FIFO_LEVEL_EN
        full      = (level_q == LVL_DEPTH);
`else
        full      = ((ram_count + PTR_W'(out_valid_q)) == PTR_DEPTH);
`endif
        s_ready   = !rst && !bus.flush && !full;
        m_valid   = out_valid_q && !bus.flush;
        push      = bus.s_valid && s_ready;
        pop       = m_valid && bus.m_ready;
        load      = !bus.flush && (!out_valid_q || bus.m_ready) && !ram_empty;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(load);
            if (load) begin
                out_valid_d = 1'b1;
            end else if (pop) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
        end
    end

    fifo_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (bus.s_data),
        .rd_en   (load),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (ram_rd_data)
    );

`ifdef STREAM_FIFO_LEVEL_EN
    always_comb begin
        level_d = level_q;
        if (bus.flush) begin
            level_d = '0;
        end else begin
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign bus.level        = level_q;
    assign bus.almost_full  = (level_q >= AF_LVL);
    assign bus.almost_empty = (level_q <= AE_LVL);
`else
    assign bus.level        = '0;
    assign bus.almost_full  = 1'b0;
    assign bus.almost_empty = 1'b0;
`endif

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid;
    assign bus.m_data  = ram_rd_data;

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - scoreboard bench for stream_fifo (DEPTH=8, AFULL=6, AEMPTY=1)
module tb_stream_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AFT   = 6;
    localparam int AET   = 1;
`ifdef STREAM_FIFO_LEVEL_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        int         acc;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stream_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    stream_fifo #(
        .DEPTH         (DEPTH),
        .DATA_WIDTH    (DW),
        .AFULL_THRESH  (AFT),
        .AEMPTY_THRESH (AET)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    entry_t     exp_q[$];
    int         cyc       = 0;
    logic       rst_q     = 1'b1;
    int         n_checks  = 0;
    int         n_fail    = 0;
    int         pop_cnt   = 0;
    bit         prod_done = 1'b0;
    logic [7:0] seq       = 8'h00;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a word accepted on edge n becomes the visible head no earlier than after edge n+1.
    always @(negedge clk) begin
        int   vis;
        logic exp_mv;
        vis = 0;
        foreach (exp_q[i]) if (exp_q[i].acc <= cyc) vis++;
        if (rst) begin
            check("rst_s_ready", bus.s_ready, 0);
            if (rst_q) begin
                check("rst_m_valid", bus.m_valid, 0);
                check("rst_m_data", bus.m_data, 0);
                check("rst_level", bus.level, 0);
                check("rst_almost_empty", bus.almost_empty, LVL);
                check("rst_almost_full", bus.almost_full, 0);
            end
            exp_q.delete();
        end else begin
            exp_mv = !bus.flush && (exp_q.size() > 0) && (exp_q[0].acc < cyc);
            if (rst_q) check("post_rst_m_data", bus.m_data, 0);
            check("s_ready", bus.s_ready, !bus.flush && (vis < DEPTH));
            check("m_valid", bus.m_valid, exp_mv);
            if (exp_mv) check("m_data", bus.m_data, exp_q[0].data);
            check("level", bus.level, LVL ? vis : 0);
            check("almost_full", bus.almost_full, LVL && (vis >= AFT));
            check("almost_empty", bus.almost_empty, LVL && (vis <= AET));
            if (bus.flush) begin
                exp_q.delete();
            end else if (exp_mv && bus.m_ready) begin
                void'(exp_q.pop_front());
                pop_cnt++;
            end
        end
    end

    task automatic send(input logic [7:0] d);
        bit ok = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                ok = 1'b1;
                exp_q.push_back('{data: d, acc: cyc + 1});
            end
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        check("send_accept", ok, 1);
    endtask

    task automatic drain();
        bus.m_ready = 1'b1;
        for (int w = 0; w < 100 && exp_q.size() != 0; w++) begin
            @(posedge clk); #1;
        end
        bus.m_ready = 1'b0;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int acc_n;
        bus.flush   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        // Reset, single push, fall-through latency
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("release_s_ready", bus.s_ready, 1);
        @(posedge clk); #1;
        send(8'h11);
        @(negedge clk);
        check("fwft_not_early", bus.m_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("fwft_m_valid", bus.m_valid, 1);
        check("fwft_m_data", bus.m_data, 8'h11);
        check("fwft_level", bus.level, LVL ? 1 : 0);
        check("fwft_aempty", bus.almost_empty, LVL);
        @(posedge clk); #1;
        drain();

        // Fill to full, hold one word at the boundary, then drain in order
        for (int i = 0; i < 8; i++) send(8'(i));
        p0 = pop_cnt;
        fork
            send(8'h08);
            begin
                @(negedge clk);
                check("full_s_ready", bus.s_ready, 0);
                check("full_level", bus.level, LVL ? 8 : 0);
                check("full_afull", bus.almost_full, LVL);
                @(posedge clk); #1;
                bus.m_ready = 1'b1;
            end
        join
        drain();
        check("full_pops", pop_cnt - p0, 9);

        // Sustained push+pop at level 4
        seq = 8'h20;
        for (int i = 0; i < 4; i++) begin
            send(seq);
            seq++;
        end
        @(posedge clk); #1;
        p0    = pop_cnt;
        acc_n = 0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = seq;
            @(negedge clk);
            if (bus.s_ready) begin
                exp_q.push_back('{data: seq, acc: cyc + 1});
                seq++;
                acc_n++;
            end
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        check("steady_pops", pop_cnt - p0, 100);
        check("steady_accepts", acc_n, 100);
        drain();

        // Random valid/ready across several pointer wraps
        p0        = pop_cnt;
        prod_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    if ($urandom_range(0, 1) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(seq);
                    seq++;
                end
                prod_done = 1'b1;
            end
            begin
                for (int w = 0; w < 3000 && !(prod_done && exp_q.size() == 0); w++) begin
                    bus.m_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                bus.m_ready = 1'b0;
            end
        join
        check("rand_drained", exp_q.size(), 0);
        check("rand_pops", pop_cnt - p0, 60);

        // Flush at level 5 with both handshakes offered
        for (int i = 0; i < 5; i++) send(8'(8'h40 + i));
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.flush   = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h55;
        bus.m_ready = 1'b1;
        @(negedge clk);
        check("flush_s_ready", bus.s_ready, 0);
        check("flush_m_valid", bus.m_valid, 0);
        @(posedge clk); #1;
        bus.flush   = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        check("post_flush_level", bus.level, 0);
        check("post_flush_m_valid", bus.m_valid, 0);
        check("post_flush_s_ready", bus.s_ready, 1);
        @(posedge clk); #1;
        send(8'hAA);
        p0 = pop_cnt;
        drain();
        check("post_flush_pops", pop_cnt - p0, 1);

        // Reset at level 3 while both sides are active
        for (int i = 0; i < 3; i++) send(8'(8'h60 + i));
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst         = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h77;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        check("mid_rst_m_valid", bus.m_valid, 0);
        check("mid_rst_m_data", bus.m_data, 0);
        check("mid_rst_level", bus.level, 0);
        check("mid_rst_aempty", bus.almost_empty, LVL);
        check("mid_rst_afull", bus.almost_full, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_release_s_ready", bus.s_ready, 1);
        @(posedge clk); #1;
        send(8'h5A);
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised synchronous FIFO with valid/ready handshakes on both sides, first-word-fall-through output, occupancy level, programmable almost-full/almost-empty thresholds and synchronous flush. It is the general-purpose buffer between the host/DMA interface and the systolic-array operand and result paths, and replaces the plain we/re FIFO for new datapaths. Storage infers block RAM.

## Interface
- `DEPTH`, 256: total capacity in words, power of two, ≥ 2
- `DATA_WIDTH`, 8: word width in bits
- `AFULL_THRESH`, DEPTH-2: `almost_full` asserts when level ≥ this value; legal range 1..DEPTH
- `AEMPTY_THRESH`, 1: `almost_empty` asserts when level ≤ this value; legal range 0..DEPTH-1
- Illegal parameter values cause an elaboration-time `$error`.

- `clk`  in  1  clock, single domain, rising edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous clear of contents, 1-cycle pulse or level
- `s_valid`  in  1  write word offered
- `s_ready`  out  1  FIFO can accept
- `s_data`  in  DATA_WIDTH  write word
- `m_valid`  out  1  head word available
- `m_ready`  in  1  consumer takes head word
- `m_data`  out  DATA_WIDTH  head word
- `level`  out  $clog2(DEPTH)+1  words held, 0..DEPTH
- `almost_full`  out  1  level ≥ AFULL_THRESH
- `almost_empty`  out  1  level ≤ AEMPTY_THRESH

## Operation
- push = `s_valid && s_ready`; pop = `m_valid && m_ready`. Only completed handshakes change state.
- Storage: DEPTH-entry RAM plus a one-word output register that holds the head word (`m_data`). `level` counts both.
- Pointers are $clog2(DEPTH)+1 bits wide. The extra MSB separates full from empty. The low bits wrap modulo DEPTH.
- Output register load: when `(!out_valid || m_ready)` and the RAM is non-empty, load it from the registered RAM read at the read pointer and advance the read pointer. When the register drains and the RAM is empty, clear `out_valid`.
- `level_next = level + push - pop`, evaluated with wide arithmetic. `level` never exceeds DEPTH and never underflows.
- `s_ready = !rst && !flush && (level < DEPTH)`.
- `m_valid = out_valid && !flush`.
- `almost_full` and `almost_empty` are combinational from the registered `level` only. They have no same-cycle input dependency.
- Ordering is strictly FIFO. Data is never duplicated or dropped.
- Flush: `s_ready` and `m_valid` are forced low, so no handshake can complete in the flush cycle. On the next edge, pointers, `level` and `out_valid` are cleared. RAM contents are not cleared.
- Priority: `rst` > `flush` > push/pop.
- Reset values: `m_valid`=0, `m_data`=0, `level`=0, `almost_empty`=1, `almost_full`=0, `s_ready`=0 while `rst` is high and 1 on the first cycle after release.

## Timing
- Fall-through latency: a word accepted at edge E into an empty FIFO is presented on `m_valid`/`m_data` after edge E+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained. Once the RAM holds at least one word, the output register reloads on the same edge as a pop, with no bubble.
- Simultaneous push and pop at level DEPTH: the push is refused because `s_ready` is 0 that cycle. At level 0 the pop cannot occur.
- `s_ready` deasserts in the cycle after the acceptance that makes `level` equal DEPTH. It reasserts in the cycle after the first pop from full.
- Upstream `s_data` must hold while `s_valid && !s_ready`. `m_data` is stable while `m_valid && !m_ready`.

## Configuration
- `STREAM_FIFO_LEVEL_EN` defined: the `level`, `almost_full` and `almost_empty` ports are driven as described above.
- Not defined: the ports remain present but are tied to 0, and the threshold logic is not synthesised. Full/empty detection uses pointer comparison instead of `level`. Handshake behaviour is identical.

## Structure
- Package `fifo_pkg` holds:
  - `is_pow2` function for parameter checks
  - default depth, width and threshold constants
- Sub-module `fifo_ram`: simple dual-port RAM with one write port and one registered read port with read enable, carrying `(* ram_style = "block" *)`. Its read-during-write to a different address is the only case used.

## Test plan
All scenarios use DEPTH=8, DATA_WIDTH=8, AFULL_THRESH=6, AEMPTY_THRESH=1, with the macro defined.
- Release reset, push 0x11 once with `m_ready`=0 → `m_valid`=1 and `m_data`=0x11 one cycle later; `level`=1, `almost_empty`=1.
- Push 0x00..0x08 with `m_ready`=0 → 0x00..0x07 accepted; `almost_full` rises at `level` 6; `s_ready`=0 at `level` 8 with 0x08 held. Then drain with `m_ready`=1 → 0x00..0x07 in order, then 0x08.
- Preload 4 words, then drive `s_valid`=`m_ready`=1 for 100 cycles → `level` stays 4, one pop per cycle, incrementing sequence intact.
- Stream 60 words with random `s_valid`/`m_ready` (50%) → scoreboard exact match across several pointer wraps; `level` matches the model every cycle.
- At `level` 5 assert `flush` with `s_valid`=`m_ready`=1 → no handshake that cycle. Next cycle `level`=0, `m_valid`=0, `s_ready`=1. A following push of 0xAA is the next word out.
- Assert `rst` at `level` 3 during streaming → next cycle all outputs at reset values. Repeat the second scenario with the macro undefined → identical data/handshake trace, with `level`, `almost_full` and `almost_empty` constant 0.
